// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo - byte-oriented UART transmitter with a small input FIFO.
//
// Sends 8N1 frames, LSB first, CLKS_PER_BIT = CLK_FREQ/BAUD clocks per bit.
// When the FIFO still holds a byte as a stop bit ends, the next frame starts
// on the same edge, so there is no idle gap between frames.
//
// Optional feature, macro UART_TX_PARITY_EN: adds an even-parity bit between
// the data bits and the stop bit, giving an 11-bit frame.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   iTXdata     byte to enqueue
//   iTXvalid    iTXdata is valid this cycle (ignored while full)
//   oTXready    FIFO can accept a byte (count != FIFO_DEPTH)
//   tx          registered serial line, idles high
//   oBusy       frame on the line or FIFO non-empty
//   oFIFOcount  FIFO occupancy, 0..FIFO_DEPTH
//
// state    | meaning
// ---------+------------------------------------------------
// S_IDLE   | line high, waiting for a queued byte
// S_START  | start bit (tx=0)
// S_DATA   | data bits, shift[0] on the line, bit_idx 0..7
// S_PARITY | even parity bit (UART_TX_PARITY_EN only)
// S_STOP   | stop bit (tx=1), may chain straight into S_START
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 4,
   localparam int AW        = $clog2(FIFO_DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    iTXdata,
   input  logic          iTXvalid,
   output logic          oTXready,
   output logic          tx,
   output logic          oBusy,
   output logic [AW:0]   oFIFOcount
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CW           = $clog2(CLKS_PER_BIT + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd4;
`endif

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   logic [2:0]    state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
`ifdef UART_TX_PARITY_EN
   logic          parity_bit;
`endif

   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          bit_end;
   logic [7:0]    head;

   assign full     = (count == (AW+1)'(FIFO_DEPTH));
   assign empty    = (count == '0);
   assign push     = iTXvalid && !full;
   assign bit_end  = (baud_cnt == CW'(CLKS_PER_BIT - 1));
   // A pop happens from IDLE, or at the last clock of a stop bit so the next
   // frame's start bit follows without an idle cycle.
   assign pop      = !empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
   assign head     = mem[rd_ptr];

   assign oTXready   = !full;
   assign oFIFOcount = count;
   assign oBusy      = (state != S_IDLE) || !empty;

   // Storage has no reset; validity is tracked by count and the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= iTXdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (pop) begin
            shift    <= head;
            state    <= S_START;
            baud_cnt <= '0;
            tx       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^head;
`endif
         end else if (state == S_IDLE) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
         end else if (!bit_end) begin
            baud_cnt <= baud_cnt + 1'b1;
         end else begin
            baud_cnt <= '0;
            case (state)
               S_START: begin
                  state   <= S_DATA;
                  bit_idx <= '0;
                  tx      <= shift[0];
               end
               S_DATA: begin
                  shift <= shift >> 1;
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                     state   <= S_PARITY;
                     tx      <= parity_bit;
`else
                     state   <= S_STOP;
                     tx      <= 1'b1;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     tx      <= shift[1];
                  end
               end
`ifdef UART_TX_PARITY_EN
               S_PARITY: begin
                  state <= S_STOP;
                  tx    <= 1'b1;
               end
`endif
               // Stop bit ending with an empty FIFO (non-empty case is the pop above).
               S_STOP: begin
                  state <= S_IDLE;
                  tx    <= 1'b1;
               end
               default: begin
                  state <= S_IDLE;
                  tx    <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with a reduced bit time (10 clocks per bit).
// The reference model tracks the FIFO as a queue and the line as a frame
// timeline: each popped byte owns FB*CPB edges starting at its pop edge, and
// the expected tx level is looked up from the bit position within that frame.
module tb_uart_tx_fifo;

   localparam int CLK_FREQ = 1000;
   localparam int BAUD     = 100;
   localparam int CPB      = CLK_FREQ / BAUD;
   localparam int DEPTH    = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FB       = 11;
`else
   localparam int FB       = 10;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] iTXdata = 8'h00;
   logic       iTXvalid = 1'b0;
   logic       oTXready;
   logic       tx;
   logic       oBusy;
   logic [2:0] oFIFOcount;

   uart_tx_fifo #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .iTXdata    (iTXdata),
      .iTXvalid   (iTXvalid),
      .oTXready   (oTXready),
      .tx         (tx),
      .oBusy      (oBusy),
      .oFIFOcount (oFIFOcount)
   );

   always #5 clk = ~clk;

   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   logic [7:0] q[$];
   bit         have_frame = 0;
   int         frame_start = 0;
   logic [7:0] frame_byte = 8'h00;

   function automatic bit line_busy();
      return have_frame && (cyc < frame_start + FB * CPB);
   endfunction

   function automatic logic exp_tx();
      int k;
      if (!line_busy()) return 1'b1;
      k = (cyc - frame_start) / CPB;
      if (k == 0) return 1'b0;
      if (k <= 8) return frame_byte[k-1];
      if (k == 9 && FB == 11) return ^frame_byte;
      return 1'b1;
   endfunction

   task automatic step(input logic r, input logic v, input logic [7:0] d);
      bit         acc;
      logic       e_tx;
      logic       e_busy;
      logic       e_rdy;
      logic [2:0] e_cnt;
      rst      = r;
      iTXvalid = v;
      iTXdata  = d;
      @(posedge clk);
      cyc++;
      if (r) begin
         q.delete();
         have_frame = 0;
      end else begin
         acc = v && (q.size() != DEPTH);
         if (q.size() != 0 && !line_busy()) begin
            frame_byte  = q.pop_front();
            frame_start = cyc;
            have_frame  = 1;
         end
         if (acc) q.push_back(d);
      end
      #1;
      e_tx   = exp_tx();
      e_busy = line_busy() || (q.size() != 0);
      e_rdy  = (q.size() != DEPTH);
      e_cnt  = 3'(q.size());
      checks++;
      assert (tx === e_tx) else begin
         errors++;
         $error("FAIL tx cyc=%0d got=%b exp=%b", cyc, tx, e_tx);
      end
      checks++;
      assert (oFIFOcount === e_cnt) else begin
         errors++;
         $error("FAIL count cyc=%0d got=%0d exp=%0d", cyc, oFIFOcount, e_cnt);
      end
      checks++;
      assert (oTXready === e_rdy) else begin
         errors++;
         $error("FAIL ready cyc=%0d got=%b exp=%b", cyc, oTXready, e_rdy);
      end
      checks++;
      assert (oBusy === e_busy) else begin
         errors++;
         $error("FAIL busy cyc=%0d got=%b exp=%b", cyc, oBusy, e_busy);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom));
   endtask

   initial begin
      int target;

      // Reset with valid held high: nothing may be accepted.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'h55);
      idle(3);

      // Single byte 0x34.
      step(1'b0, 1'b1, 8'h34);
      idle(FB * CPB + 10);

      // Three bytes back to back, no idle gap between frames.
      step(1'b0, 1'b1, 8'h34);
      step(1'b0, 1'b1, 8'h38);
      step(1'b0, 1'b1, 8'h32);
      idle(3 * FB * CPB + 10);

      // Six bytes on consecutive cycles: 0x06 meets a full FIFO and is dropped.
      for (int b = 1; b <= 6; b++) step(1'b0, 1'b1, 8'(b));
      idle(5 * FB * CPB + 10);

      // Reset during data bit 3 of 0xA5 with two bytes queued.
      step(1'b0, 1'b1, 8'hA5);
      target = cyc + 1 + 4 * CPB + 3;
      step(1'b0, 1'b1, 8'hC3);
      step(1'b0, 1'b1, 8'h0F);
      while (cyc < target - 1) step(1'b0, 1'b0, 8'($urandom));
      step(1'b1, 1'b0, 8'h00);
      idle(3 * FB * CPB);

      // Parity cases: three ones, then four ones.
      step(1'b0, 1'b1, 8'h34);
      idle(FB * CPB + 5);
      step(1'b0, 1'b1, 8'h33);
      idle(FB * CPB + 5);

      // Random traffic: sparse pushes mixed with bursts that hit full.
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            for (int j = 0; j < 6; j++) step(1'b0, 1'b1, 8'($urandom));
         end else begin
            step(1'b0, ($urandom_range(0, 29) == 0), 8'($urandom));
         end
      end
      idle((DEPTH + 1) * FB * CPB + 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
